// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its environment: redirect/enable
// inputs, the I-cache request/response port and the fetch-queue write side.
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LINE_WIDTH = 128
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  enable;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_gnt;
    logic                  ic_rvalid;
    logic [LINE_WIDTH-1:0] ic_rdata;
    logic                  fq_push;
    logic [LINE_WIDTH-1:0] fq_data;
    logic                  fq_flush;
    logic [1:0]            fq_offset;
    logic [CW-1:0]         fq_wp;
    logic [CW-1:0]         fq_rp;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        input  enable, redirect_valid, redirect_pc, ic_gnt, ic_rvalid, ic_rdata,
               fq_wp, fq_rp,
        output ic_req, ic_addr, fq_push, fq_data, fq_flush, fq_offset, busy, pc
    );

    modport slave (
        output enable, redirect_valid, redirect_pc, ic_gnt, ic_rvalid, ic_rdata,
               fq_wp, fq_rp,
        input  ic_req, ic_addr, fq_push, fq_data, fq_flush, fq_offset, busy, pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one line-aligned I-cache request at a time when the
// fetch queue has room for a full line, pushes responses, flushes on redirect.
module fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LINE_WIDTH = 128
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [CW-1:0]         occ_s;
    logic                  room_s;
    logic                  req_s;
    logic                  push_s;
    logic                  flush_s;
    logic [ADDR_WIDTH-1:0] line_s;

    // Queue occupancy, room check and the per-cycle handshake strobes.
    always_comb begin
        occ_s   = bus.fq_wp - bus.fq_rp;
        room_s  = (occ_s <= CW'(DEPTH - 4));
        line_s  = {pc_r[ADDR_WIDTH-1:4], 4'b0000};
        req_s   = 1'b0;
        push_s  = 1'b0;
        flush_s = 1'b0;
        if (reset) begin
            flush_s = bus.redirect_valid;
            req_s   = (state_r == REQ) && room_s && !bus.redirect_valid;
            push_s  = (state_r == WAIT) && bus.ic_rvalid && !bus.redirect_valid;
        end else begin
            req_s   = 1'b0;
            push_s  = 1'b0;
            flush_s = 1'b0;
        end
    end

    assign bus.ic_req    = req_s;
    assign bus.ic_addr   = line_s;
    assign bus.fq_push   = push_s;
    assign bus.fq_data   = bus.ic_rdata;
    assign bus.fq_flush  = flush_s;
    assign bus.fq_offset = flush_s ? bus.redirect_pc[3:2] : 2'b00;
    assign bus.busy      = (state_r != IDLE);
    assign bus.pc        = pc_r;

    // Sequencer state and fetch PC; a redirect overrides every other transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            pc_r    <= '0;
        end else if (bus.redirect_valid) begin
            pc_r <= bus.redirect_pc;
            case (state_r)
                IDLE:       state_r <= bus.enable ? REQ : IDLE;
                // a grant in the redirect cycle still owes us a response
                REQ:        state_r <= (bus.ic_gnt && room_s) ? DROP : REQ;
                WAIT, DROP: state_r <= bus.ic_rvalid ? REQ : DROP;
                default:    state_r <= IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.enable) state_r <= REQ;
                    else            state_r <= IDLE;
                end
                REQ: begin
                    if (req_s && bus.ic_gnt)         state_r <= WAIT;
                    else if (!bus.enable && !req_s)  state_r <= IDLE;
                    else                             state_r <= REQ;
                end
                WAIT: begin
                    if (bus.ic_rvalid) begin
                        pc_r    <= line_s + ADDR_WIDTH'(16);
                        state_r <= bus.enable ? REQ : IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DROP: begin
                    if (bus.ic_rvalid) state_r <= bus.enable ? REQ : IDLE;
                    else               state_r <= DROP;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    fetch_ctrl_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .waiting  ((state_r == WAIT) || (state_r == DROP)),
        .ic_rvalid(bus.ic_rvalid),
        .fq_push  (push_s),
        .fq_flush (flush_s)
    );
endmodule

// Protocol checks: responses only while one is outstanding, push/flush exclusive.
module fetch_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic waiting,
    input logic ic_rvalid,
    input logic fq_push,
    input logic fq_flush
);
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!reset)
        ic_rvalid |-> waiting);
    a_push_flush_excl: assert property (@(posedge clk) disable iff (!reset)
        !(fq_push && fq_flush));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a transaction-level model of the controller,
// the I-cache and the fetch queue predicts every handshake output each cycle.
module tb_fetch_ctrl;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int LW    = 128;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LINE_WIDTH(LW)) bus ();

    fetch_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LINE_WIDTH(LW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // model of the fetch stream: where fetching stands, whether a line is in
    // flight and whether that line has been made stale by a redirect
    logic [AW-1:0] m_pc;
    bit            m_active;
    bit            m_out;
    bit            m_stale;
    int            wcnt;
    logic [CW-1:0] wp, rp, occ;
    logic [LW-1:0] rd;
    logic [AW-1:0] rpc, line;
    bit            redir, rv, room, e_req, e_push, en, gnt;
    int            pct;

    initial begin
        reset              = 1'b0;
        bus.enable         = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.ic_gnt         = 1'b0;
        bus.ic_rvalid      = 1'b0;
        bus.ic_rdata       = 128'h0;
        wp = 7'd0; rp = 7'd0;
        bus.fq_wp = wp; bus.fq_rp = rp;
        m_pc = 32'h0; m_active = 1'b0; m_out = 1'b0; m_stale = 1'b0; wcnt = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ic_req",   128'(bus.ic_req),    128'(1'b0));
        chk("rst_fq_push",  128'(bus.fq_push),   128'(1'b0));
        chk("rst_fq_flush", 128'(bus.fq_flush),  128'(1'b0));
        chk("rst_offset",   128'(bus.fq_offset), 128'(2'b00));
        chk("rst_busy",     128'(bus.busy),      128'(1'b0));
        chk("rst_pc",       128'(bus.pc),        128'(32'h0));

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            bus.fq_wp = wp;
            bus.fq_rp = rp;
            reset = (cyc > 20 && $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            en    = ($urandom_range(0, 9) != 0);
            redir = reset && ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'h0000_1008;
                1:       rpc = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001C);
                default: rpc = $urandom;
            endcase
            gnt  = ($urandom_range(0, 1) == 1);
            rv   = m_out && (wcnt == 0);
            rd   = {$urandom, $urandom, $urandom, $urandom};
            bus.enable         = en;
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            bus.ic_gnt         = gnt;
            bus.ic_rvalid      = rv;
            bus.ic_rdata       = rd;
            #1;

            occ    = wp - rp;
            room   = (occ <= 7'(DEPTH - 4));
            line   = {m_pc[AW-1:4], 4'h0};
            e_req  = m_active && !m_out && room && !redir;
            e_push = m_out && !m_stale && rv && !redir;
            if (reset) begin
                chk("ic_req", 128'(bus.ic_req), 128'(e_req));
                if (e_req) chk("ic_addr", 128'(bus.ic_addr), 128'(line));
                chk("fq_push", 128'(bus.fq_push), 128'(e_push));
                if (e_push) chk("fq_data", bus.fq_data, rd);
                chk("fq_flush", 128'(bus.fq_flush), 128'(redir));
                if (redir) chk("fq_offset", 128'(bus.fq_offset), 128'(rpc[3:2]));
            end
            chk("busy", 128'(bus.busy), 128'(m_active || m_out));
            chk("pc", 128'(bus.pc), 128'(m_pc));

            // advance the model to what must hold after this clock edge
            if (!reset) begin
                m_pc = 32'h0; m_active = 1'b0; m_out = 1'b0; m_stale = 1'b0; wcnt = 0;
            end else if (redir) begin
                if (m_out) begin
                    if (rv) begin
                        m_out = 1'b0; m_stale = 1'b0; m_active = 1'b1;
                    end else begin
                        m_stale = 1'b1; wcnt--;
                    end
                end else if (m_active && room && gnt) begin
                    m_out = 1'b1; m_stale = 1'b1; wcnt = $urandom_range(0, 3);
                end else begin
                    m_active = m_active || en;
                end
                m_pc = rpc;
            end else if (m_out) begin
                if (rv) begin
                    if (!m_stale) m_pc = line + 32'd16;
                    m_out = 1'b0; m_stale = 1'b0; m_active = en;
                end else begin
                    wcnt--;
                end
            end else if (m_active) begin
                if (e_req && gnt) begin
                    m_out = 1'b1; m_stale = 1'b0; wcnt = $urandom_range(0, 3);
                end else if (!en && !e_req) begin
                    m_active = 1'b0;
                end
            end else begin
                m_active = en;
            end

            // queue side: flush empties it, a pushed line adds four words
            if (reset && redir) wp = rp;
            if (reset && e_push) wp = wp + 7'd4;
            case ((cyc / 400) % 3)
                0:       pct = 80;
                1:       pct = 25;
                default: pct = 4;
            endcase
            if ((wp != rp) && ($urandom_range(0, 99) < pct)) rp = rp + 7'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
